// File: rtl/cpu_md_pkg.sv
// Shared multiply/divide definitions: op encodings and unit state, also used
// by decode and hazard logic.
package cpu_md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101,
    MD_NOP6  = 3'b110,
    MD_NOP7  = 3'b111
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  // True for the ops that occupy the unit for MUL_LAT cycles.
  function automatic logic md_is_mul(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  // True for the ops that occupy the unit for DIV_LAT cycles.
  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational multiply/divide datapath. Produces the HI/LO pair for the
// op presented; divide-by-zero and signed overflow are resolved here so the
// sequencer only has to register and commit the result.
module md_compute
  import cpu_md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] prod_s;
  logic        [2*WIDTH-1:0] prod_u;
  logic signed [WIDTH-1:0]   a_s;
  logic signed [WIDTH-1:0]   b_s;
  logic signed [WIDTH-1:0]   quot_s;
  logic signed [WIDTH-1:0]   rem_s;
  logic        [WIDTH-1:0]   quot_u;
  logic        [WIDTH-1:0]   rem_u;

  // Evaluate all four arithmetic results and select by op.
  always_comb begin
    prod_s = $signed({{WIDTH{a_i[WIDTH-1]}}, a_i}) * $signed({{WIDTH{b_i[WIDTH-1]}}, b_i});
    prod_u = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
    a_s    = $signed(a_i);
    b_s    = $signed(b_i);
    quot_s = '0;
    rem_s  = '0;
    quot_u = '0;
    rem_u  = '0;
    if (b_i == '0) begin
      // Divide by zero: quotient all ones, remainder is the dividend.
      quot_s = '1;
      rem_s  = a_s;
      quot_u = '1;
      rem_u  = a_i;
    end else begin
      quot_u = a_i / b_i;
      rem_u  = a_i % b_i;
      if ((a_i == MOST_NEG) && (b_i == '1)) begin
        // Signed overflow: the true quotient is unrepresentable.
        quot_s = MOST_NEG;
        rem_s  = '0;
      end else begin
        quot_s = a_s / b_s;
        rem_s  = a_s % b_s;
      end
    end

    hi_o = '0;
    lo_o = '0;
    case (op_i)
      MD_MULT:  begin hi_o = prod_s[2*WIDTH-1:WIDTH]; lo_o = prod_s[WIDTH-1:0]; end
      MD_MULTU: begin hi_o = prod_u[2*WIDTH-1:WIDTH]; lo_o = prod_u[WIDTH-1:0]; end
      MD_DIV:   begin hi_o = rem_s;                   lo_o = quot_s;            end
      MD_DIVU:  begin hi_o = rem_u;                   lo_o = quot_u;            end
      default:  begin hi_o = '0;                      lo_o = '0;                end
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. The result is
// computed and captured at accept, then committed to HI/LO after the op
// latency; MTHI/MTLO write directly when the unit is idle.
module mul_div_unit
  import cpu_md_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] comp_hi;
  logic [WIDTH-1:0] comp_lo;

  md_compute #(
    .WIDTH(WIDTH)
  ) u_compute (
    .op_i (md_op),
    .a_i  (rs),
    .b_i  (rt),
    .hi_o (comp_hi),
    .lo_o (comp_lo)
  );

  // State, counter and result registers; reset discards any in-flight op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
    end
  end

  // Accept/sequence/commit logic; starts while busy are dropped.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (md_is_mul(md_op) || md_is_div(md_op)) begin
            state_d  = ST_BUSY;
            cnt_d    = md_is_mul(md_op) ? MUL_CNT : DIV_CNT;
            res_hi_d = comp_hi;
            res_lo_d = comp_lo;
          end else if (md_op == MD_MTHI) begin
            hi_d = rs;
          end else if (md_op == MD_MTLO) begin
            lo_d = rs;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end
        // The edge that brings the counter to zero is the completion edge.
        if (cnt_q <= CNT_ONE) begin
          state_d = ST_IDLE;
          hi_d    = res_hi_q;
          lo_d    = res_lo_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state_q == ST_BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit at default parameters.
module tb_mul_div_unit;
  import cpu_md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul_div_unit #(
    .WIDTH   (32),
    .MUL_LAT (5),
    .DIV_LAT (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .rs    (rs),
    .rt    (rt),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    md_op = op;
    rs    = a;
    rt    = b;
    tick();
    start = 1'b0;
  endtask

  // Count edges until busy drops, checking HI/LO stay frozen meanwhile and
  // scrambling operands to show they were captured at accept.
  task automatic wait_done(input string tag, input int exp_lat);
    int          lat;
    logic [31:0] ph;
    logic [31:0] pl;
    ph  = hi;
    pl  = lo;
    lat = 0;
    while (busy && lat < 100) begin
      chk({tag, "_hold_hi"}, hi, ph);
      chk({tag, "_hold_lo"}, lo, pl);
      rs = $urandom;
      rt = $urandom;
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    md_op = '0;
    rs    = '0;
    rt    = '0;
    #2;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    tick();
    reset = 1'b0;

    // MULT -3 * 5
    issue(MD_MULT, 32'hFFFF_FFFD, 32'd5);
    chk("mult_busy", {31'b0, busy}, 32'h1);
    wait_done("mult", 5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFF1);

    // MULTU max * max
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu", 5);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    // DIVU 100 / 7
    issue(MD_DIVU, 32'd100, 32'd7);
    chk("divu_busy", {31'b0, busy}, 32'h1);
    wait_done("divu", 10);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    // DIV -7 / 2
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg", 10);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);

    // DIV by zero
    issue(MD_DIV, 32'h1234_5678, 32'h0);
    wait_done("div0", 10);
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    chk("div0_hi", hi, 32'h1234_5678);

    // DIV overflow
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 10);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'h0);

    // DIVU by zero
    issue(MD_DIVU, 32'd5, 32'h0);
    wait_done("divu0", 10);
    chk("divu0_lo", lo, 32'hFFFF_FFFF);
    chk("divu0_hi", hi, 32'd5);

    // MTLO with start held for two edges
    start = 1'b1;
    md_op = MD_MTLO;
    rs    = 32'hA5A5_A5A5;
    rt    = 32'h0;
    tick();
    chk("mtlo_lo", lo, 32'hA5A5_A5A5);
    chk("mtlo_hi", hi, 32'd5);
    chk("mtlo_busy", {31'b0, busy}, 32'h0);
    tick();
    start = 1'b0;
    chk("mtlo_held_lo", lo, 32'hA5A5_A5A5);

    // MTHI
    issue(MD_MTHI, 32'h0BAD_F00D, 32'h0);
    chk("mthi_hi", hi, 32'h0BAD_F00D);
    chk("mthi_lo", lo, 32'hA5A5_A5A5);
    chk("mthi_busy", {31'b0, busy}, 32'h0);

    // No-op encodings change nothing
    issue(MD_NOP6, 32'hDEAD_BEEF, 32'h1);
    issue(MD_NOP7, 32'hDEAD_BEEF, 32'h1);
    chk("nop_hi", hi, 32'h0BAD_F00D);
    chk("nop_lo", lo, 32'hA5A5_A5A5);
    chk("nop_busy", {31'b0, busy}, 32'h0);

    // DIV 7/2 with MULT and MTHI requests arriving mid-operation
    issue(MD_DIV, 32'd7, 32'd2);
    tick();
    start = 1'b1;
    md_op = MD_MULT;
    rs    = 32'd2;
    rt    = 32'd3;
    tick();
    md_op = MD_MTHI;
    rs    = 32'hFFFF_0000;
    tick();
    start = 1'b0;
    chk("ign_busy", {31'b0, busy}, 32'h1);
    wait_done("ign", 7);
    chk("ign_lo", lo, 32'd3);
    chk("ign_hi", hi, 32'd1);

    // Reset in busy cycle 3 of a MULTU
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("rstmid_hi", hi, 32'h0);
    chk("rstmid_lo", lo, 32'h0);
    chk("rstmid_busy", {31'b0, busy}, 32'h0);
    tick();
    reset = 1'b0;
    issue(MD_MTHI, 32'h600D_CAFE, 32'h0);
    chk("postrst_mthi", hi, 32'h600D_CAFE);
    repeat (8) tick();
    chk("postrst_hi", hi, 32'h600D_CAFE);
    chk("postrst_lo", lo, 32'h0);
    chk("postrst_busy", {31'b0, busy}, 32'h0);

    // Back-to-back: DIV on the completion edge is ignored, accepted next edge
    issue(MD_MULT, 32'd2, 32'd3);
    repeat (4) tick();
    chk("b2b_busy4", {31'b0, busy}, 32'h1);
    start = 1'b1;
    md_op = MD_DIV;
    rs    = 32'd7;
    rt    = 32'd2;
    tick();
    chk("b2b_done_busy", {31'b0, busy}, 32'h0);
    chk("b2b_mult_lo", lo, 32'd6);
    chk("b2b_mult_hi", hi, 32'd0);
    tick();
    start = 1'b0;
    chk("b2b_div_busy", {31'b0, busy}, 32'h1);
    wait_done("b2b_div", 10);
    chk("b2b_div_lo", lo, 32'd3);
    chk("b2b_div_hi", hi, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
